// File: rtl/sram_dp_wm_param_pkg.sv
// Shared definitions for the parameterised dual-port SRAM model.
// Holds the collision-mode constants and the legality check for the read
// latency, which both the top level and the read pipeline use.
package sram_dp_wm_param_pkg;

  // Value a cross-port read returns when the other port writes the same lane
  localparam int COLL_OLD = 0;
  localparam int COLL_NEW = 1;

  // Only one or two output register stages exist
  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/sram_dp_wm_param_if.sv
// Bus bundle for both ports of sram_dp_wm_param.
// Per port X in {A, B}:
//   CENX   port enable, active low
//   WENX   per-lane write enables, active low (1 = read that lane)
//   AX     word address
//   DX     write data
//   QX     read data (holds between accesses)
//   VALIDX one-cycle pulse when QX carries a new access result
// Shared: COLL (collision pulse) and COLL_CNT (saturating collision count).
// master = the client driving accesses, slave = the memory.
interface sram_dp_wm_param_if #(
  parameter int BITS       = 64,
  parameter int ADDR_WIDTH = 15,
  parameter int LANES      = 2,
  parameter int CNT_W      = 16
);
  logic                  CENA;
  logic [LANES-1:0]      WENA;
  logic [ADDR_WIDTH-1:0] AA;
  logic [BITS-1:0]       DA;
  logic [BITS-1:0]       QA;
  logic                  VALIDA;

  logic                  CENB;
  logic [LANES-1:0]      WENB;
  logic [ADDR_WIDTH-1:0] AB;
  logic [BITS-1:0]       DB;
  logic [BITS-1:0]       QB;
  logic                  VALIDB;

  logic                  COLL;
  logic [CNT_W-1:0]      COLL_CNT;

  modport master (
    output CENA, WENA, AA, DA, CENB, WENB, AB, DB,
    input  QA, VALIDA, QB, VALIDB, COLL, COLL_CNT
  );

  modport slave (
    input  CENA, WENA, AA, DA, CENB, WENB, AB, DB,
    output QA, VALIDA, QB, VALIDB, COLL, COLL_CNT
  );
endinterface

// File: rtl/sram_rd_pipe.sv
// Per-port read delay line of DEPTH register stages carrying {valid, data}.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   in_valid   an access happened this cycle
//   in_data    result of that access (already lane-merged)
//   out_valid  one-cycle pulse DEPTH edges after the access
//   out_data   last delivered result; holds while no access arrives
module sram_rd_pipe #(
  parameter int BITS  = 64,
  parameter int DEPTH = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  output logic [BITS-1:0] out_data
);
  import sram_dp_wm_param_pkg::*;

  if (!rd_lat_ok(DEPTH)) begin : g_bad_depth
    $error("sram_rd_pipe: DEPTH must be 1 or 2");
  end

  logic [DEPTH-1:0] v;
  logic [BITS-1:0]  d [DEPTH];

  // Data only advances together with its valid bit, so the final stage keeps
  // showing the last result through idle cycles. Reset drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
endmodule

// File: rtl/sram_dp_wm_param.sv
// Behavioural true-dual-port SRAM with per-lane write masks, write-through,
// configurable read latency and same-address collision detection.
// Ports:
//   CLK  clock shared by both ports
//   RST  asynchronous active-high reset of all control/output state
//        (the array itself keeps its contents)
//   bus  slave side of sram_dp_wm_param_if (port A/B accesses, QX/VALIDX,
//        COLL pulse and saturating COLL_CNT)
module sram_dp_wm_param #(
  parameter int BITS       = 64,
  parameter int WORD_DEPTH = 32768,
  parameter int ADDR_WIDTH = 15,
  parameter int LANES      = 2,
  parameter int RD_LAT     = 1,
  parameter int COLL_NEW   = 0,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  sram_dp_wm_param_if.slave bus
);
  import sram_dp_wm_param_pkg::*;

  localparam int                  LW        = BITS / LANES;
  localparam int                  IW        = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(WORD_DEPTH);
  localparam bit                  RET_NEW   = (COLL_NEW != COLL_OLD);
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("sram_dp_wm_param: RD_LAT must be 1 or 2");
  end
  if (BITS % LANES != 0) begin : g_bad_lanes
    $error("sram_dp_wm_param: BITS must be divisible by LANES");
  end

  logic [BITS-1:0] mem [WORD_DEPTH];

  logic            run;
  logic            acc_a, acc_b, in_a, in_b, coll;
  logic [IW-1:0]   ia_a, ia_b;
  logic [BITS-1:0] old_a, old_b, res_a, res_b;
  logic            coll_q;
  logic [CNT_W-1:0] cnt_q;

  // run is low on the first edge after reset release, so an access presented
  // in that cycle is ignored entirely (no write, no read result).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) run <= 1'b0;
    else     run <= 1'b1;
  end

  assign acc_a = run && !bus.CENA;
  assign acc_b = run && !bus.CENB;
  assign in_a  = {1'b0, bus.AA} < DEPTH_LIM;
  assign in_b  = {1'b0, bus.AB} < DEPTH_LIM;
  assign ia_a  = bus.AA[IW-1:0];
  assign ia_b  = bus.AB[IW-1:0];
  assign coll  = acc_a && acc_b && in_a && (bus.AA == bus.AB);

  // Lane merge: own write lanes echo own data; read lanes see the old word,
  // or the other port's write data when it hits the same lane and the
  // new-data collision mode is selected. Out-of-range reads return zero.
  always_comb begin
    old_a = in_a ? mem[ia_a] : '0;
    old_b = in_b ? mem[ia_b] : '0;
    res_a = '0;
    res_b = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!bus.WENA[k])                        res_a[k*LW +: LW] = bus.DA[k*LW +: LW];
      else if (RET_NEW && coll && !bus.WENB[k]) res_a[k*LW +: LW] = bus.DB[k*LW +: LW];
      else                                     res_a[k*LW +: LW] = old_a[k*LW +: LW];
      if (!bus.WENB[k])                        res_b[k*LW +: LW] = bus.DB[k*LW +: LW];
      else if (RET_NEW && coll && !bus.WENA[k]) res_b[k*LW +: LW] = bus.DA[k*LW +: LW];
      else                                     res_b[k*LW +: LW] = old_b[k*LW +: LW];
    end
  end

  // Port B's writes are issued after port A's so B wins a shared lane.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < LANES; k++)
      if (acc_a && in_a && !bus.WENA[k]) mem[ia_a][k*LW +: LW] <= bus.DA[k*LW +: LW];
    for (int k = 0; k < LANES; k++)
      if (acc_b && in_b && !bus.WENB[k]) mem[ia_b][k*LW +: LW] <= bus.DB[k*LW +: LW];
  end

  // Collision flag always has one cycle of latency regardless of RD_LAT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      coll_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      coll_q <= coll;
      if (coll && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.COLL     = coll_q;
  assign bus.COLL_CNT = cnt_q;

  sram_rd_pipe #(.BITS(BITS), .DEPTH(RD_LAT)) u_pipe_a (
    .clk       (CLK),
    .rst       (RST),
    .in_valid  (acc_a),
    .in_data   (res_a),
    .out_valid (bus.VALIDA),
    .out_data  (bus.QA)
  );

  sram_rd_pipe #(.BITS(BITS), .DEPTH(RD_LAT)) u_pipe_b (
    .clk       (CLK),
    .rst       (RST),
    .in_valid  (acc_b),
    .in_data   (res_b),
    .out_valid (bus.VALIDB),
    .out_data  (bus.QB)
  );
endmodule
